// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
//
// Round-robin arbiter that shares the single push port of a downstream FIFO
// among NUM_REQ valid/ready requesters. A shadow occupancy count keeps the
// arbiter from ever pushing into a full FIFO. Any push_err_on_full reported
// by the FIFO is latched as a sticky protocol error.
//
// Ports
//   clk                    clock, rising edge
//   rst                    asynchronous active-high reset
//   req_valid   [NUM_REQ]  per-requester valid
//   req_data    [NUM_REQ*DATA_W] payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready   [NUM_REQ]  one-hot grant (combinational); transfer on valid&ready
//   fifo_push              registered push strobe to the FIFO
//   fifo_data_in [DATA_W]  registered payload to the FIFO
//   fifo_pop               consumer pop strobe seen by the FIFO
//   fifo_empty             FIFO empty flag
//   fifo_full              FIFO full flag (informational only)
//   fifo_push_err_on_full  FIFO error: push while full
//   occupancy   [CNT_W]    shadow entry count (includes the in-flight push)
//   proto_err              sticky protocol error, cleared only by rst
// ---------------------------------------------------------------------------
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_push,
    output logic [DATA_W-1:0]           fifo_data_in,
    input  logic                        fifo_pop,
    input  logic                        fifo_empty,
    input  logic                        fifo_full,
    input  logic                        fifo_push_err_on_full,
    output logic [CNT_W-1:0]            occupancy,
    output logic                        proto_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    logic [PTR_W-1:0]  ptr_reg;
    logic              fifo_push_reg;
    logic [DATA_W-1:0] fifo_data_reg;
    logic [CNT_W-1:0]  occupancy_reg;
    logic [CNT_W-1:0]  occupancy_next;
    logic              proto_err_reg;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic              pop_valid;
    logic [DATA_W-1:0] lane_data [NUM_REQ];

    // fifo_full is not used for gating: the shadow count already leads the
    // FIFO by one cycle, so it is the authoritative full indicator.
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

    // Split the packed payload bus into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
            // Grant is forced low while reset is asserted.
            assign req_ready[gi] = grant_found && !rst && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // Round-robin search starting at ptr_reg; blocked entirely when the
    // shadow count says the FIFO (plus in-flight push) is full.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        if (occupancy_reg < DEPTH_CNT) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_reg) + k) % NUM_REQ;
                if (!grant_found && req_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx[PTR_W-1:0];
                end
            end
        end
    end

    // Only pops the FIFO actually honours reduce the count.
    assign pop_valid = fifo_pop && !fifo_empty;

    always_comb begin
        occupancy_next = occupancy_reg;
        case ({grant_found, pop_valid})
            2'b10:   occupancy_next = occupancy_reg + ONE_CNT;
            2'b01:   occupancy_next = occupancy_reg - ONE_CNT;
            default: occupancy_next = occupancy_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            fifo_push_reg <= 1'b0;
            fifo_data_reg <= '0;
            occupancy_reg <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            fifo_push_reg <= grant_found;
            if (grant_found) begin
                fifo_data_reg <= lane_data[grant_idx];
                ptr_reg       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            occupancy_reg <= occupancy_next;
            if (fifo_push_err_on_full) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign fifo_push    = fifo_push_reg;
    assign fifo_data_in = fifo_data_reg;
    assign occupancy    = occupancy_reg;
    assign proto_err    = proto_err_reg;

endmodule
